// File: rtl/ttl_74193_ctrl.sv
// Sequencer for a cascaded chain of 74193-style up/down counters.
// Emits registered CPU/CPD/PL_bar/MR strobes and keeps a shadow copy of the count.
//
// state      | meaning
// IDLE       | sampling requests (ignored while MR_OUT still high)
// LOAD_LO    | PL_bar_OUT held low for PULSE_LO cycles
// CNT_LO     | CPU_OUT or CPD_OUT held low for PULSE_LO cycles
// HOLD_HI    | all strobes high for SETTLE cycles, ripple into upper chip settles
// POST_RST   | extra MR_OUT cycle after MR drops
module ttl_74193_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PULSE_LO = 1,
  parameter int SETTLE   = 1
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             REQ_LD,
  input  logic             REQ_UP,
  input  logic             REQ_DN,
  input  logic [WIDTH-1:0] LD_DATA,
  output logic             ACK,
  output logic             BUSY,
  output logic             CPU_OUT,
  output logic             CPD_OUT,
  output logic             PL_bar_OUT,
  output logic             MR_OUT,
  output logic [WIDTH-1:0] D_OUT,
  output logic [WIDTH-1:0] Q_SHADOW,
  output logic             TC_UP,
  output logic             TC_DN
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_LO  = 3'd1;
  localparam logic [2:0] S_CNT_LO   = 3'd2;
  localparam logic [2:0] S_HOLD_HI  = 3'd3;
  localparam logic [2:0] S_POST_RST = 3'd4;

  // Timers count down to zero; the terminal count ends the phase.
  localparam logic [3:0] LO_START = 4'(PULSE_LO - 1);
  localparam logic [3:0] HI_START = 4'(SETTLE - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       timer_q, timer_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             cpu_q, cpu_d;
  logic             cpd_q, cpd_d;
  logic             pl_q, pl_d;
  logic             mr_out_q, mr_out_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ack_d    = 1'b0;
    cpu_d    = cpu_q;
    cpd_d    = cpd_q;
    pl_d     = pl_q;
    mr_out_d = mr_out_q;
    d_d      = d_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (mr_out_q) begin
          state_d = S_POST_RST;
        end else if (REQ_LD) begin
          ack_d   = 1'b1;
          d_d     = LD_DATA;
          pl_d    = 1'b0;
          timer_d = LO_START;
          state_d = S_LOAD_LO;
        end else if (REQ_UP ^ REQ_DN) begin
          ack_d   = 1'b1;
          cpu_d   = ~REQ_UP;
          cpd_d   = ~REQ_DN;
          timer_d = LO_START;
          state_d = S_CNT_LO;
        end else if (REQ_UP && REQ_DN) begin
          ack_d = 1'b1;
        end
      end
      S_LOAD_LO: begin
        if (timer_q == 4'd0) begin
          pl_d     = 1'b1;
          shadow_d = d_q;
          timer_d  = HI_START;
          state_d  = S_HOLD_HI;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_CNT_LO: begin
        if (timer_q == 4'd0) begin
          cpu_d    = 1'b1;
          cpd_d    = 1'b1;
          // The low strobe tells which direction is being counted.
          shadow_d = cpu_q ? shadow_q - WIDTH'(1) : shadow_q + WIDTH'(1);
          timer_d  = HI_START;
          state_d  = S_HOLD_HI;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_HOLD_HI: begin
        if (timer_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_POST_RST: begin
        mr_out_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state_q  <= S_IDLE;
      timer_q  <= 4'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      cpu_q    <= 1'b1;
      cpd_q    <= 1'b1;
      pl_q     <= 1'b1;
      mr_out_q <= 1'b1;
      d_q      <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      cpu_q    <= cpu_d;
      cpd_q    <= cpd_d;
      pl_q     <= pl_d;
      mr_out_q <= mr_out_d;
      d_q      <= d_d;
      shadow_q <= shadow_d;
    end
  end

  assign ACK        = ack_q;
  assign BUSY       = busy_q;
  assign CPU_OUT    = cpu_q;
  assign CPD_OUT    = cpd_q;
  assign PL_bar_OUT = pl_q;
  assign MR_OUT     = mr_out_q;
  assign D_OUT      = d_q;
  assign Q_SHADOW   = shadow_q;
  assign TC_UP      = &shadow_q;
  assign TC_DN      = ~|shadow_q;

endmodule

// File: doc/ttl_74193_ctrl.md
Name: ttl_74193_ctrl

Overview:
Synchronous sequencer that drives a cascaded chain of up/down counter chips from single-clock logic. The chain is built from 74193-style counters, which count on the rising edges of CPU/CPD and have async MR/PL_bar.
- Arbitrates level requests: load, count-up, count-down.
- Emits glitch-free, registered CPU/CPD/PL_bar/MR strobes with programmable low and settle times.
- Keeps a shadow copy of the expected count, so CPU-side logic (stack pointer, loop counters) can read the value without sampling the ripple chain.

Parameters:
WIDTH, 8, total counter width (8 = two cascaded 4-bit chips)
PULSE_LO, 1, cycles a strobe (CPU/CPD/PL_bar) is held low; legal range 1..15
SETTLE, 1, cycles strobes stay high after release before the next command; legal range 1..15

Ports:
CP  input  1  system clock, all state changes on rising edge
MR  input  1  synchronous reset, active high
REQ_LD  input  1  request parallel load of LD_DATA
REQ_UP  input  1  request increment
REQ_DN  input  1  request decrement
LD_DATA  input  WIDTH  load value, sampled when a load is accepted
ACK  output  1  one-cycle pulse: a request was accepted this edge
BUSY  output  1  high while an operation is in progress (not IDLE)
CPU_OUT  output  1  to counter CPU pin, idle high
CPD_OUT  output  1  to counter CPD pin, idle high
PL_bar_OUT  output  1  to counter PL_bar pin, idle high
MR_OUT  output  1  to counter MR pin, active high
D_OUT  output  WIDTH  to counter D pins, holds last accepted load value
Q_SHADOW  output  WIDTH  expected counter value
TC_UP  output  1  Q_SHADOW == all ones (combinational)
TC_DN  output  1  Q_SHADOW == 0 (combinational)

Behaviour:
- Reset (MR high at an edge):
  - State goes to IDLE; CPU_OUT, CPD_OUT and PL_bar_OUT are 1.
  - MR_OUT is 1, and stays 1 for one extra cycle after MR drops.
  - ACK=0, BUSY=0, Q_SHADOW=0, D_OUT=0, timers cleared.
  - Reset mid-operation aborts at that edge: any low strobe returns high and no shadow update occurs.
- All outputs except TC_UP/TC_DN are registered.
- States:
  - IDLE
  - LOAD_LO
  - CNT_LO
  - HOLD_HI
  - POST_RST (the extra MR_OUT cycle; requests ignored)
- Requests are sampled only in IDLE and are level-sensitive. A request held high is re-accepted each time IDLE is re-entered, giving one ACK per operation.
- Priority in IDLE: REQ_LD > (REQ_UP xor REQ_DN).
  - REQ_UP and REQ_DN together with no REQ_LD: ACK=1, no strobe, Q_SHADOW unchanged, stay IDLE.
- Load accept at edge t:
  - ACK=1; D_OUT<=LD_DATA; PL_bar_OUT<=0; state LOAD_LO.
  - After PULSE_LO cycles low: PL_bar_OUT<=1, Q_SHADOW<=D_OUT, state HOLD_HI.
- Up/down accept at edge t:
  - ACK=1; CPU_OUT<=0 (or CPD_OUT<=0); state CNT_LO.
  - After PULSE_LO cycles: strobe<=1 (the rising edge that counts), Q_SHADOW<=Q_SHADOW±1 modulo 2^WIDTH, state HOLD_HI.
- HOLD_HI: all strobes high for SETTLE cycles, covering the TCU_bar/TCD_bar ripple into the upper chip; then IDLE. BUSY=1 in every non-IDLE state.
- Throughput: one operation per 1+PULSE_LO+SETTLE cycles. With defaults: accept edge t, release edge t+1, IDLE at t+2, next accept at t+3.
- Only one of CPU_OUT/CPD_OUT/PL_bar_OUT is ever low at a time, and never while MR_OUT=1.
- Wrap-around:
  - Up from all ones gives 0.
  - Down from 0 gives all ones.
  - TC flags follow Q_SHADOW and need no special handling.
- D_OUT is stable from the accept edge through the end of HOLD_HI and holds afterwards.

Test Plan:
- Reset: MR=1 for 2 cycles, then 0 -> MR_OUT high through the first cycle after MR falls. Strobes=1, Q_SHADOW=0x00, TC_DN=1, BUSY=0.
- Load: REQ_LD=1, LD_DATA=0xA5 for one cycle in IDLE -> ACK at t, PL_bar_OUT low exactly cycle t..t+1, D_OUT=0xA5, Q_SHADOW=0xA5 after edge t+1, BUSY low at t+2.
- Up wrap: load 0xFF, hold REQ_UP for 6 cycles -> CPU_OUT low-pulses at 3-cycle spacing, two ACKs, Q_SHADOW 0xFF->0x00->0x01. TC_UP drops when 0x00 is reached.
- Down wrap with PULSE_LO=3, SETTLE=2: from 0x00 issue one REQ_DN -> CPD_OUT low 3 cycles, then Q_SHADOW=0xFF, TC_UP=1, IDLE 2 cycles after release.
- Conflicts:
  - REQ_UP=REQ_DN=1 -> ACK, no strobe, Q_SHADOW unchanged.
  - REQ_LD=REQ_UP=1 -> load wins, no CPU_OUT pulse.
- Abort: assert MR while CPU_OUT is low in CNT_LO -> CPU_OUT=1 at the next edge, Q_SHADOW=0, MR_OUT=1, no counting edge while MR_OUT is high.
